// File: rtl/am2911_sequencer.sv
// Am2911-style microprogram address sequencer slice: uPC / AR / 4-deep stack / D source mux.
// Optional build macro AM2911_STACK_STATUS_EN adds registered FULL/EMPTY stack status outputs.
module am2911_sequencer #(
    parameter int WIDTH       = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic             cp,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             re_n,
    input  logic [1:0]       s,
    input  logic             zero_n,
    input  logic             oe_n,
    input  logic             cn,
    input  logic             fe_n,
    input  logic             pup,
`ifdef AM2911_STACK_STATUS_EN
    output logic             full,
    output logic             empty,
`endif
    output logic [WIDTH-1:0] y,
    output logic             cn4
);

    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        SRC_UPC   = 2'b00,
        SRC_AR    = 2'b01,
        SRC_STACK = 2'b10,
        SRC_D     = 2'b11
    } src_e;

    logic [WIDTH-1:0] upc;
    logic [WIDTH-1:0] ar;
    logic [WIDTH-1:0] stack [STACK_DEPTH];
    logic [PW-1:0]    sp;
    logic [PW-1:0]    sp_inc;
    logic [PW-1:0]    sp_dec;
    logic [WIDTH-1:0] a;

    assign sp_inc = sp + 1'b1;
    assign sp_dec = sp - 1'b1;

    always_comb begin
        a = '0;
        if (zero_n) begin
            case (src_e'(s))
                SRC_UPC:   a = upc;
                SRC_AR:    a = ar;
                SRC_STACK: a = stack[sp];
                SRC_D:     a = d;
                default:   a = '0;
            endcase
        end
    end

    // A feeds the incrementer whether or not Y is driven.
    assign y   = oe_n ? {WIDTH{1'bz}} : a;
    assign cn4 = cn & (&a);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            upc <= '0;
            ar  <= '0;
        end else begin
            upc <= a + {{(WIDTH-1){1'b0}}, cn};
            if (!re_n)
                ar <= d;
        end
    end

    // NOTE: the stack words are reset because a pop from empty must return a known word.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            sp <= '0;
            for (int i = 0; i < STACK_DEPTH; i++)
                stack[i] <= '0;
        end else if (!fe_n) begin
            if (pup) begin
                sp            <= sp_inc;
                stack[sp_inc] <= upc;
            end else begin
                sp <= sp_dec;
            end
        end
    end

`ifdef AM2911_STACK_STATUS_EN
    localparam logic [PW:0] DEPTH_MAX = (PW+1)'(STACK_DEPTH);

    // Depth saturates while SP keeps wrapping, so status reflects valid entries only.
    logic [PW:0] depth;

    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            depth <= '0;
        end else if (!fe_n) begin
            if (pup) begin
                if (depth != DEPTH_MAX)
                    depth <= depth + 1'b1;
            end else if (depth != '0) begin
                depth <= depth - 1'b1;
            end
        end
    end

    assign empty = (depth == '0);
    assign full  = (depth == DEPTH_MAX);
`endif

endmodule
